// File: rtl/rfalumem_ctrl.sv
// Multi-cycle control FSM for an RV32I subset datapath (R/I ALU, LW, SW).
// Accepts one instruction per handshake and sequences RF/ALU/memory strobes.
module rfalumem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NAME_BITS  = 5,
  parameter int CTRL_BITS  = 4,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [31:0]           instr,
  output logic                  instr_ready,
  output logic [NAME_BITS-1:0]  rs1,
  output logic [NAME_BITS-1:0]  rs2,
  output logic [NAME_BITS-1:0]  ws,
  output logic [CTRL_BITS-1:0]  op,
  output logic                  imm_e,
  output logic [DATA_WIDTH-1:0] imm_d,
  output logic                  reg_we,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic                  done,
  output logic                  illegal,
  output logic [CNT_BITS-1:0]   retired
);

  typedef enum logic [2:0] {
    IDLE, DECODE, EXEC, MEM, WB
  } state_t;

  localparam logic [CTRL_BITS-1:0] OP_AND = CTRL_BITS'(0);
  localparam logic [CTRL_BITS-1:0] OP_OR  = CTRL_BITS'(1);
  localparam logic [CTRL_BITS-1:0] OP_ADD = CTRL_BITS'(2);
  localparam logic [CTRL_BITS-1:0] OP_SUB = CTRL_BITS'(6);
  localparam logic [CTRL_BITS-1:0] OP_SLT = CTRL_BITS'(7);

  state_t                state_q;
  logic                  ready_q, reg_we_q, mem_re_q, mem_we_q;
  logic                  done_q, illegal_q, load_q, store_q;
  logic [NAME_BITS-1:0]  rs1_q, rs2_q, ws_q;
  logic [CTRL_BITS-1:0]  op_q;
  logic                  imm_e_q;
  logic [DATA_WIDTH-1:0] immd_q;
  logic [CNT_BITS-1:0]   retired_q;

  logic [6:0]            opc, f7;
  logic [2:0]            f3;
  logic [DATA_WIDTH-1:0] imm_i, imm_s;
  logic                  legal_d, load_d, store_d, imm_e_d;
  logic [CTRL_BITS-1:0]  op_d;
  logic [DATA_WIDTH-1:0] immd_d;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};

  // Decoded on the accept edge so fields are visible while in DECODE.
  always_comb begin
    legal_d = 1'b0;
    load_d  = 1'b0;
    store_d = 1'b0;
    imm_e_d = 1'b0;
    op_d    = OP_ADD;
    immd_d  = imm_i;
    unique case (opc)
      7'b0110011: begin
        unique case ({f7, f3})
          10'b0000000_000: begin legal_d = 1'b1; op_d = OP_ADD; end
          10'b0100000_000: begin legal_d = 1'b1; op_d = OP_SUB; end
          10'b0000000_010: begin legal_d = 1'b1; op_d = OP_SLT; end
          10'b0000000_110: begin legal_d = 1'b1; op_d = OP_OR;  end
          10'b0000000_111: begin legal_d = 1'b1; op_d = OP_AND; end
          default: ;
        endcase
      end
      7'b0010011: begin
        imm_e_d = 1'b1;
        unique case (f3)
          3'b000: begin legal_d = 1'b1; op_d = OP_ADD; end
          3'b010: begin legal_d = 1'b1; op_d = OP_SLT; end
          3'b110: begin legal_d = 1'b1; op_d = OP_OR;  end
          3'b111: begin legal_d = 1'b1; op_d = OP_AND; end
          default: ;
        endcase
      end
      7'b0000011: begin
        imm_e_d = 1'b1;
        load_d  = (f3 == 3'b010);
        legal_d = load_d;
      end
      7'b0100011: begin
        imm_e_d = 1'b1;
        immd_d  = imm_s;
        store_d = (f3 == 3'b010);
        legal_d = store_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      reg_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      ws_q      <= '0;
      op_q      <= '0;
      imm_e_q   <= 1'b0;
      immd_q    <= '0;
      retired_q <= '0;
    end else begin
      reg_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      if (done_q) retired_q <= retired_q + CNT_BITS'(1);
      unique case (state_q)
        IDLE: begin
          if (instr_valid && ready_q) begin
            state_q   <= DECODE;
            ready_q   <= 1'b0;
            rs1_q     <= NAME_BITS'(instr[19:15]);
            rs2_q     <= NAME_BITS'(instr[24:20]);
            ws_q      <= NAME_BITS'(instr[11:7]);
            op_q      <= op_d;
            imm_e_q   <= imm_e_d;
            immd_q    <= immd_d;
            illegal_q <= !legal_d;
            load_q    <= load_d;
            store_q   <= store_d;
          end
        end
        DECODE: begin
          if (illegal_q) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (load_q || store_q) begin
            state_q  <= MEM;
            mem_re_q <= load_q;
            mem_we_q <= store_q;
            done_q   <= store_q;
          end else begin
            state_q  <= WB;
            reg_we_q <= |ws_q;
            done_q   <= 1'b1;
          end
        end
        MEM: begin
          if (load_q) begin
            state_q  <= WB;
            mem_re_q <= 1'b1;
            reg_we_q <= |ws_q;
            done_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        WB: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign ws          = ws_q;
  assign op          = op_q;
  assign imm_e       = imm_e_q;
  assign imm_d       = immd_q;
  assign reg_we      = reg_we_q;
  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_rfalumem_ctrl.sv
// Scoreboard bench for rfalumem_ctrl: random instructions vs. a decode model.
// A narrow retired counter makes wrap-around happen during the random run.
module tb_rfalumem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready, imm_e, reg_we, mem_re, mem_we, done, illegal;
  logic [4:0]  rs1, rs2, ws;
  logic [3:0]  op;
  logic [31:0] imm_d;
  logic [3:0]  retired;

  rfalumem_ctrl #(
    .DATA_WIDTH(32), .NAME_BITS(5), .CTRL_BITS(4), .CNT_BITS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rs1(rs1), .rs2(rs2), .ws(ws), .op(op),
    .imm_e(imm_e), .imm_d(imm_d),
    .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
    .done(done), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  // trace[k] = {ready, reg_we, mem_re, mem_we, done, illegal} at cycle k+1
  typedef struct packed {
    logic            legal;
    logic [4:0]      rs1, rs2, ws;
    logic [3:0]      op;
    logic            imm_e;
    logic [31:0]     immv;
    logic [4:0][5:0] tr;
    logic [2:0]      n;
    logic [3:0]      ret;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 1'b0;
  bit          mon_busy = 1'b0;
  int unsigned model_cnt = 0;

  logic [5:0]  stb;
  logic [51:0] fields;
  assign stb    = {instr_ready, reg_we, mem_re, mem_we, done, illegal};
  assign fields = {rs1, rs2, ws, op, imm_e, imm_e ? imm_d : 32'h0};

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] alu_code(input logic [2:0] f3);
    case (f3)
      3'd0:    return 4'b0010;
      3'd2:    return 4'b0111;
      3'd6:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] w);
    exp_t       e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    bit         ld, st, alu, we;
    e = '0;
    opc = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    ld = 0; st = 0; alu = 0;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.ws  = w[11:7];
    e.op  = 4'b0010;
    if (opc == 7'h33 && f7 == 7'h00 && f3 inside {0, 2, 6, 7}) begin
      alu = 1; e.op = alu_code(f3);
    end else if (opc == 7'h33 && f7 == 7'h20 && f3 == 0) begin
      alu = 1; e.op = 4'b0110;
    end else if (opc == 7'h13 && f3 inside {0, 2, 6, 7}) begin
      alu = 1; e.op = alu_code(f3); e.imm_e = 1;
      e.immv = {{20{w[31]}}, w[31:20]};
    end else if (opc == 7'h03 && f3 == 2) begin
      ld = 1; e.imm_e = 1;
      e.immv = {{20{w[31]}}, w[31:20]};
    end else if (opc == 7'h23 && f3 == 2) begin
      st = 1; e.imm_e = 1;
      e.immv = {{20{w[31]}}, w[31:25], w[11:7]};
    end
    e.legal = alu | ld | st;
    we = (e.ws != 0);
    if (!e.legal) begin
      e.n = 2; e.tr[0] = 6'b000001; e.tr[1] = 6'b100000;
    end else if (alu) begin
      e.n = 4; e.tr[2] = {1'b0, we, 4'b0010}; e.tr[3] = 6'b100000;
    end else if (ld) begin
      e.n = 5; e.tr[2] = 6'b001000;
      e.tr[3] = {1'b0, we, 4'b1010}; e.tr[4] = 6'b100000;
    end else begin
      e.n = 4; e.tr[2] = 6'b000110; e.tr[3] = 6'b100000;
    end
    return e;
  endfunction

  function automatic logic [51:0] exp_fields(input exp_t e);
    return {e.rs1, e.rs2, e.ws, e.op, e.imm_e, e.imm_e ? e.immv : 32'h0};
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] r;
    logic [2:0]  f3s[4];
    logic [6:0]  opcs[4];
    int          k;
    f3s  = '{3'd0, 3'd2, 3'd6, 3'd7};
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23};
    r = $urandom;
    case ($urandom % 6)
      0: begin
        k = int'($urandom % 5);
        if (k == 4) return {7'h20, r[24:15], 3'd0, r[11:7], 7'h33};
        return {7'h00, r[24:15], f3s[k], r[11:7], 7'h33};
      end
      1: return {r[31:15], f3s[$urandom % 4], r[11:7], 7'h13};
      2: return {r[31:15], 3'b010, r[11:7], 7'h03};
      3: return {r[31:15], 3'b010, r[11:7], 7'h23};
      4: return r;
      default: return {r[31:7], opcs[$urandom % 4]};
    endcase
  endfunction

  task automatic issue(input logic [31:0] w);
    exp_t e;
    int   t;
    e = model(w);
    if (e.legal) model_cnt++;
    e.ret = 4'(model_cnt);
    q.push_back(e);
    instr_valid = 1'b1;
    instr = w;
    t = 0;
    forever begin
      @(negedge clk);
      if (instr_ready) break;
      t++;
      if (t > 20) begin
        $display("FAIL accept_timeout: ready=%0b after %0d cycles", instr_ready, t);
        $fatal(1, "no accept");
      end
    end
    @(posedge clk); #1;
    instr_valid = 1'($urandom % 2);
    instr = $urandom;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat ($urandom % 2) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !mon_busy) break;
    end
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    exp_t cur;
    int   idx;
    idx = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        mon_busy = 1'b0;
      end else begin
        if (mon_busy) begin
          chk($sformatf("strobes_c%0d", idx), 64'(stb), 64'(cur.tr[idx-1]));
          if (idx == 1 && cur.legal)
            chk("fields_decode", 64'(fields), 64'(exp_fields(cur)));
          if (idx == int'(cur.n)) begin
            chk("retired", 64'(retired), 64'(cur.ret));
            if (cur.legal)
              chk("fields_hold", 64'(fields), 64'(exp_fields(cur)));
            mon_busy = 1'b0;
          end else begin
            idx++;
          end
        end else begin
          chk("idle_strobes", 64'(stb), 64'(6'b100000));
        end
        if (!mon_busy && instr_valid && instr_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_accept", 64'(instr), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            cur = q.pop_front();
            mon_busy = 1'b1;
            idx = 1;
          end
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_strobes", 64'(stb), 64'(6'b100000));
    chk("reset_retired", 64'(retired), 64'h0);
    chk("reset_fields", 64'(fields), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    issue(32'h00500093);
    issue(32'h402081B3);
    issue(32'hFFC0A283);
    issue(32'h0050A423);
    issue(32'h00100013);
    issue(32'h0000007F);
    repeat (150) issue(gen());
    drain();

    mon_en = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b1;
    instr = 32'h002081B3;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_ready", 64'(instr_ready), 64'h1);
    chk("rst_strobes", 64'(stb), 64'(6'b100000));
    chk("rst_retired", 64'(retired), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 64'({stb, retired}), 64'({6'b100000, 4'h0}));
    end
    @(posedge clk); #1;
    model_cnt = 0;
    mon_en = 1'b1;

    repeat (60) issue(gen());
    drain();
    chk("queue_drain", 64'(q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rfalumem_ctrl.md
# rfalumem_ctrl

Multi-cycle control FSM that sequences the register-file / ALU / data-memory datapath for a RISC-V RV32I subset (R-type ALU, I-type ALU, LW, SW). The block accepts one 32-bit instruction at a time over a valid/ready handshake, decodes it, and drives the datapath's control inputs cycle by cycle until the instruction retires. It sits between the instruction source (fetch stage or testbench) and the datapath.

## Interface

Parameters:
- DATA_WIDTH, 32, datapath and immediate width
- NAME_BITS, 5, register specifier width
- CTRL_BITS, 4, ALU control width
- CNT_BITS, 16, retired-instruction counter width

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr  in  32  instruction word
- instr_ready  out  1  FSM can accept; high only in IDLE
- rs1, rs2  out  NAME_BITS  register-file read selects
- ws  out  NAME_BITS  register-file write select
- op  out  CTRL_BITS  ALU control
- imm_e  out  1  select imm_d as ALU operand b
- imm_d  out  DATA_WIDTH  sign-extended immediate
- reg_we  out  1  register-file write enable
- mem_re  out  1  memory read; also selects memory data as write-back source
- mem_we  out  1  memory write
- done  out  1  one-cycle pulse on retirement
- illegal  out  1  one-cycle pulse on undecodable instruction
- retired  out  CNT_BITS  count of retired instructions

## Operation

- States: IDLE, DECODE, EXEC, MEM, WB. All outputs are registered.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr, go to DECODE.
- DECODE: decode the latched word; load rs1=instr[19:15], rs2=instr[24:20], ws=instr[11:7], op, imm_e, imm_d. Legal -> EXEC; illegal -> pulse illegal, go to IDLE (no datapath strobes).
- EXEC: ALU computes; R/I-type -> WB; LW/SW -> MEM.
- MEM: LW: mem_re=1 -> WB. SW: mem_we=1, done=1 -> IDLE.
- WB: reg_we=1 unless ws==0; done=1; mem_re=1 for LW only -> IDLE.
- rs1/rs2/ws/op/imm_e/imm_d hold from DECODE until the next DECODE; strobes (reg_we, mem_re, mem_we, done, illegal) are high only in the states listed.
- Decode (opcode, funct3, funct7 -> op):
  - 0110011: 000/0000000 ADD 0010; 000/0100000 SUB 0110; 010/0000000 SLT 0111; 110/0000000 OR 0001; 111/0000000 AND 0000; imm_e=0.
  - 0010011: 000 ADDI ADD; 010 SLTI SLT; 110 ORI OR; 111 ANDI AND; imm_e=1, imm_d=sext(instr[31:20]).
  - 0000011 funct3 010 (LW): op=ADD, imm_e=1, imm_d=sext(instr[31:20]).
  - 0100011 funct3 010 (SW): op=ADD, imm_e=1, imm_d=sext({instr[31:25],instr[11:7]}).
  - Any other combination is illegal.
- retired increments by 1 on every done pulse, wraps from all-ones to 0; illegal instructions do not count.
- Reset (asynchronous, any state): state=IDLE; every output 0 except instr_ready=1; retired=0. Instruction in flight is dropped with no strobes.

## Timing

- Accept edge = cycle 0.
- R/I-type: DECODE c1, EXEC c2, WB c3 (reg_we, done), IDLE c4 (instr_ready=1). Throughput: 1 instruction / 4 cycles.
- LW: DECODE c1, EXEC c2, MEM c3 (mem_re), WB c4 (mem_re, reg_we, done), IDLE c5.
- SW: DECODE c1, EXEC c2, MEM c3 (mem_we, done), IDLE c4.
- Illegal: DECODE c1 (illegal), IDLE c2.
- instr_valid outside IDLE is ignored; instr is sampled only on the accept edge.
- Back-to-back: valid held high in IDLE is accepted on the first IDLE edge; no idle bubble beyond the IDLE cycle.

## Test plan

- Reset: assert rst mid-EXEC of an ADD -> same cycle state IDLE, reg_we=0, instr_ready=1, retired=0; no write-back follows.
- ADDI x1,x0,5 (0x00500093) -> c1: rs1=0, ws=1, op=0010, imm_e=1, imm_d=5; c3: reg_we=1, done=1; c4: instr_ready=1, retired=1.
- SUB x3,x1,x2 (0x402081B3) -> op=0110, imm_e=0, rs1=1, rs2=2, ws=3; reg_we at c3.
- LW x5,-4(x1) (0xFFC0A283) -> imm_d=0xFFFFFFFC; mem_re high c3 and c4; reg_we only c4; SW x5,8(x1) (0x0050A423) -> imm_d=8, mem_we at c3 only, reg_we never.
- ADDI x0,x0,1 -> done at c3 with reg_we=0; retired increments. Opcode 0x7F word -> illegal pulse at c1, no strobes, retired unchanged, ready at c2.
- Force retired to all-ones, retire one ADD -> retired=0.
